// File: rtl/if_write_addr_gen.sv
// if_write_addr_gen
//   Write-side address generator for the IF scratch buffer. Streams a row of
//   feature words into a circular scratch (IF_SCRATCH_DEPTH entries). It tracks
//   the write pointer, the oldest live entry and the row's last address.
//   Entries are released by win_done (stride_len entries per window) and the
//   whole row is dropped by row_done.
//
// Optional feature: define IF_WRITE_OVERFLOW_CHK_EN to add the sticky
// overflow_err output. It flags a word offered while the scratch is full, or a
// release larger than the live count.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           pulse: begin a row (IDLE only)
//   in_valid/in_data/in_last/in_ready  input word stream; in_ready is combinational
//   stride_len      entries released per window
//   win_done        pulse: current window consumed
//   row_done        pulse: row fully consumed
//   scratch_wen/scratch_wdata  scratch write port (same cycle as acceptance)
//   IF_waddr        next write address (also the scratch write address)
//   IF_start_pos    oldest live entry
//   IF_end_pos      address of the row's last word, qualified by IF_end_valid
//   occupancy       live entry count
//   overflow_err    sticky overflow flag (only with IF_WRITE_OVERFLOW_CHK_EN)

module if_write_addr_gen #(
    parameter int unsigned IF_ADDR_LEN      = 4,
    parameter int unsigned IF_SCRATCH_DEPTH = 16,
    parameter int unsigned IF_SCRATCH_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [IF_SCRATCH_WIDTH-1:0] in_data,
    input  logic                        in_last,
    output logic                        in_ready,
    input  logic [IF_ADDR_LEN-1:0]      stride_len,
    input  logic                        win_done,
    input  logic                        row_done,
    output logic                        scratch_wen,
    output logic [IF_SCRATCH_WIDTH-1:0] scratch_wdata,
    output logic [IF_ADDR_LEN-1:0]      IF_waddr,
    output logic [IF_ADDR_LEN-1:0]      IF_start_pos,
    output logic [IF_ADDR_LEN-1:0]      IF_end_pos,
    output logic                        IF_end_valid,
    output logic [IF_ADDR_LEN:0]        occupancy
`ifdef IF_WRITE_OVERFLOW_CHK_EN
    ,
    output logic                        overflow_err
`endif
);

    localparam int unsigned OCC_W = IF_ADDR_LEN + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(IF_SCRATCH_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [IF_ADDR_LEN-1:0]  waddr_d;
    logic [IF_ADDR_LEN-1:0]  start_pos_d;
    logic [IF_ADDR_LEN-1:0]  end_pos_d;
    logic                    end_valid_d;
    logic [OCC_W-1:0]        occ_d;
    logic                    wr;
    logic                    active;
    logic                    row_ev;
    logic                    win_ev;
    logic [OCC_W-1:0]        rel;

    // Circular add; base < DEPTH and inc <= DEPTH, so one subtraction suffices.
    function automatic logic [IF_ADDR_LEN-1:0] wrap_add(
        input logic [IF_ADDR_LEN-1:0] base,
        input logic [OCC_W-1:0]       inc
    );
        logic [OCC_W-1:0] sum;
        sum = OCC_W'(base) + inc;
        if (sum >= DEPTH_OCC) begin
            sum = sum - DEPTH_OCC;
        end
        return IF_ADDR_LEN'(sum);
    endfunction

    // Zero-latency acceptance straight into the scratch write port.
    assign in_ready      = (state_q == FILL) && (occupancy < DEPTH_OCC);
    assign wr            = in_valid & in_ready;
    assign scratch_wen   = wr;
    assign scratch_wdata = in_data;

    // Release events are only meaningful while a row is live; row_done wins.
    assign active = (state_q != IDLE);
    assign row_ev = active & row_done;
    assign win_ev = active & win_done & ~row_done;
    assign rel    = (OCC_W'(stride_len) < occupancy) ? OCC_W'(stride_len) : occupancy;

    // State and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            IF_waddr     <= '0;
            IF_start_pos <= '0;
            IF_end_pos   <= '0;
            IF_end_valid <= 1'b0;
            occupancy    <= '0;
        end else begin
            state_q      <= state_d;
            IF_waddr     <= waddr_d;
            IF_start_pos <= start_pos_d;
            IF_end_pos   <= end_pos_d;
            IF_end_valid <= end_valid_d;
            occupancy    <= occ_d;
        end
    end

    // Next-state and next-pointer logic.
    always_comb begin
        state_d     = state_q;
        waddr_d     = IF_waddr;
        start_pos_d = IF_start_pos;
        end_pos_d   = IF_end_pos;
        end_valid_d = IF_end_valid;
        occ_d       = occupancy;

        case (state_q)
            IDLE:    if (start)          state_d = FILL;
            FILL:    if (wr && in_last)  state_d = HOLD;
            HOLD:    if (row_done)       state_d = IDLE;
            default:                     state_d = IDLE;
        endcase

        if (row_ev) begin
            // Next row starts right after this row's last word.
            waddr_d     = wrap_add(IF_end_pos, OCC_W'(1));
            start_pos_d = wrap_add(IF_end_pos, OCC_W'(1));
            occ_d       = '0;
            end_valid_d = 1'b0;
        end else begin
            if (wr) begin
                waddr_d = wrap_add(IF_waddr, OCC_W'(1));
                if (in_last) begin
                    end_pos_d   = IF_waddr;
                    end_valid_d = 1'b1;
                end
            end
            if (win_ev) begin
                start_pos_d = wrap_add(IF_start_pos, rel);
            end
            // rel never exceeds the pre-edge occupancy, so this cannot underflow.
            occ_d = occupancy + OCC_W'(wr) - (win_ev ? rel : '0);
        end
    end

`ifdef IF_WRITE_OVERFLOW_CHK_EN
    // Sticky: word offered while full, or release larger than the live count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (((state_q == FILL) && in_valid && (occupancy == DEPTH_OCC)) ||
                     (win_ev && (OCC_W'(stride_len) > occupancy))) begin
            overflow_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_write_addr_gen.sv
// Testbench for if_write_addr_gen (DEPTH=8, ADDR_LEN=4, WIDTH=16).
// A queue-based reference model predicts each scratch write and the pointer
// outputs; a negedge monitor pops expected writes as the DUT presents them.
module tb_if_write_addr_gen;

    localparam int unsigned AW = 4;
    localparam int unsigned D  = 8;
    localparam int unsigned DW = 16;

    localparam int M_IDLE = 0;
    localparam int M_FILL = 1;
    localparam int M_HOLD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic [AW-1:0] stride_len;
    logic          win_done;
    logic          row_done;
    logic          scratch_wen;
    logic [DW-1:0] scratch_wdata;
    logic [AW-1:0] IF_waddr;
    logic [AW-1:0] IF_start_pos;
    logic [AW-1:0] IF_end_pos;
    logic          IF_end_valid;
    logic [AW:0]   occupancy;
`ifdef IF_WRITE_OVERFLOW_CHK_EN
    logic          overflow_err;
`endif

    if_write_addr_gen #(
        .IF_ADDR_LEN(AW),
        .IF_SCRATCH_DEPTH(D),
        .IF_SCRATCH_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_last(in_last),
        .in_ready(in_ready),
        .stride_len(stride_len),
        .win_done(win_done),
        .row_done(row_done),
        .scratch_wen(scratch_wen),
        .scratch_wdata(scratch_wdata),
        .IF_waddr(IF_waddr),
        .IF_start_pos(IF_start_pos),
        .IF_end_pos(IF_end_pos),
        .IF_end_valid(IF_end_valid),
        .occupancy(occupancy)
`ifdef IF_WRITE_OVERFLOW_CHK_EN
        ,
        .overflow_err(overflow_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard of expected scratch writes.
    typedef struct {
        int addr;
        int data;
    } wr_t;
    wr_t sb[$];

    // Reference model: live entries kept as a FIFO of addresses.
    int m_state, m_waddr, m_start, m_end;
    bit m_endv, m_ovf;
    int m_live[$];

    task automatic model_reset();
        m_state = M_IDLE; m_waddr = 0; m_start = 0; m_end = 0;
        m_endv = 0; m_ovf = 0;
        m_live.delete();
    endtask

    // Monitor: every DUT write must match the oldest predicted write.
    always @(negedge clk) begin
        if (scratch_wen === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", int'(IF_waddr), e.addr);
                check("wr_data", int'(scratch_wdata), e.data);
            end
        end
    end

    task automatic check_regs();
        check("IF_waddr", int'(IF_waddr), m_waddr);
        check("IF_start_pos", int'(IF_start_pos), m_start);
        check("IF_end_pos", int'(IF_end_pos), m_end);
        check("IF_end_valid", int'(IF_end_valid), int'(m_endv));
        check("occupancy", int'(occupancy), m_live.size());
`ifdef IF_WRITE_OVERFLOW_CHK_EN
        check("overflow_err", int'(overflow_err), int'(m_ovf));
`endif
    endtask

    // One clock cycle: called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input bit s, input bit v, input int d, input bit l,
                         input int str, input bit w, input bit r);
        int  occ, rel, nstate;
        bit  ready, wr, act;
        start = s; in_valid = v; in_data = DW'(d); in_last = l;
        stride_len = AW'(str); win_done = w; row_done = r;
        #1;
        occ   = m_live.size();
        ready = (m_state == M_FILL) && (occ < D);
        wr    = v && ready;
        check("in_ready", int'(in_ready), int'(ready));
        check("scratch_wen", int'(scratch_wen), int'(wr));
        if (wr) sb.push_back('{addr: m_waddr, data: d & 16'hFFFF});

        nstate = m_state;
        if (m_state == M_IDLE && s) nstate = M_FILL;
        else if (m_state == M_FILL && wr && l) nstate = M_HOLD;
        else if (m_state == M_HOLD && r) nstate = M_IDLE;

        act = (m_state != M_IDLE);
        if (m_state == M_FILL && v && occ == D) m_ovf = 1;
        if (act && w && !r && str > occ) m_ovf = 1;

        if (act && r) begin
            m_waddr = (m_end + 1) % D;
            m_start = m_waddr;
            m_live.delete();
            m_endv = 0;
        end else begin
            rel = (str < occ) ? str : occ;
            if (wr) begin
                m_live.push_back(m_waddr);
                if (l) begin m_end = m_waddr; m_endv = 1; end
                m_waddr = (m_waddr + 1) % D;
            end
            if (act && w) begin
                repeat (rel) void'(m_live.pop_front());
                m_start = (m_start + rel) % D;
            end
        end
        m_state = nstate;

        @(posedge clk); #1;
        check_regs();
    endtask

    task automatic idle_cyc();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic word(input bit l);
        cycle(0, 1, int'($urandom_range(0, 65535)), l, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 0; in_valid = 0; in_data = '0; in_last = 0;
        stride_len = '0; win_done = 0; row_done = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_wen", int'(scratch_wen), 0);
        check("rst_waddr", int'(IF_waddr), 0);
        check("rst_start_pos", int'(IF_start_pos), 0);
        check("rst_end_pos", int'(IF_end_pos), 0);
        check("rst_end_valid", int'(IF_end_valid), 0);
        check("rst_occupancy", int'(occupancy), 0);
        rst = 1'b0;

        // Basic row: 5 words, last on the 5th.
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) word(i == 5);
        check("basic_waddr", int'(IF_waddr), 5);
        check("basic_end_pos", int'(IF_end_pos), 4);
        check("basic_end_valid", int'(IF_end_valid), 1);
        check("basic_occ", int'(occupancy), 5);
        check("basic_hold_ready", int'(in_ready), 0);
        cycle(0, 0, 0, 0, 3, 1, 1);

        // Row ending at address 7, closed by row_done together with win_done.
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) word(i == 3);
        check("rowend_end_pos", int'(IF_end_pos), 7);
        cycle(0, 0, 0, 0, 2, 1, 1);
        check("rowend_start_pos", int'(IF_start_pos), 0);
        check("rowend_waddr", int'(IF_waddr), 0);
        check("rowend_occ", int'(occupancy), 0);
        check("rowend_end_valid", int'(IF_end_valid), 0);
        cycle(0, 1, 16'h1234, 0, 0, 0, 0);   // IDLE: no write

        // Row of 6 words leaves start_pos at 6, then the wrap row.
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) word(i == 6);
        cycle(0, 0, 0, 0, 0, 0, 1);
        check("wrap_start_pos", int'(IF_start_pos), 6);
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) word(i == 4);
        check("wrap_waddr", int'(IF_waddr), 2);
        cycle(0, 0, 0, 0, 0, 0, 1);

        // Empty release, then fill to full with one extra word.
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 3, 1, 0);
        check("empty_start_pos", int'(IF_start_pos), 2);
        check("empty_occ", int'(occupancy), 0);
        for (int i = 1; i <= 9; i++) word(0);
        check("full_occ", int'(occupancy), 8);
        check("full_ready", int'(in_ready), 0);
`ifdef IF_WRITE_OVERFLOW_CHK_EN
        check("full_overflow", int'(overflow_err), 1);
`endif
        cycle(0, 0, 0, 0, 2, 1, 0);
        check("release_occ", int'(occupancy), 6);
        check("release_start_pos", int'(IF_start_pos), 4);
        word(1);
        cycle(0, 0, 0, 0, 0, 0, 1);

        // Reset mid-FILL at occupancy 3.
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) word(0);
        check("pre_rst_occ", int'(occupancy), 3);
        start = 0; in_valid = 0; in_last = 0; win_done = 0; row_done = 0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_waddr", int'(IF_waddr), 0);
        check("async_rst_start", int'(IF_start_pos), 0);
        check("async_rst_end", int'(IF_end_pos), 0);
        check("async_rst_occ", int'(occupancy), 0);
        check("async_rst_ready", int'(in_ready), 0);
`ifdef IF_WRITE_OVERFLOW_CHK_EN
        check("async_rst_ovf", int'(overflow_err), 0);
`endif
        model_reset();
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;

        // After reset: first write at 0; then write coincident with release.
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("post_rst_waddr", int'(IF_waddr), 0);
        for (int i = 1; i <= 6; i++) word(0);
        check("sim_pre_occ", int'(occupancy), 6);
        cycle(0, 1, 16'hBEEF, 0, 2, 1, 0);
        check("sim_occ", int'(occupancy), 5);
        check("sim_start_pos", int'(IF_start_pos), 2);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            bit s, v, l, w, r;
            s = (m_state == M_IDLE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 9) == 0);
            w = ($urandom_range(0, 4) == 0);
            r = (m_state != M_FILL) && ($urandom_range(0, 3) == 0);
            cycle(s, v, int'($urandom_range(0, 65535)), l,
                  int'($urandom_range(0, 10)), w, r);
        end

        idle_cyc();
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
